// File: rtl/agu_pipe.sv
`timescale 1ns/1ps
// agu_pipe: two-stage segment:offset address generator with valid/ready flow
// control. Stage 1 selects and sums the effective offset; stage 2 forms the
// physical address and checks the segment limit. Holds up to two requests.
module agu_pipe #(
    parameter int OFS_W     = 16,
    parameter int SEG_W     = 16,
    parameter int SEG_SHIFT = 4,
    parameter int ADDR_W    = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [OFS_W-1:0]  in_rel,
    input  logic [SEG_W-1:0]  in_seg,
    input  logic [OFS_W-1:0]  in_ip,
    input  logic [OFS_W-1:0]  in_reg1,
    input  logic [OFS_W-1:0]  in_reg2,
    input  logic [OFS_W-1:0]  in_limit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [OFS_W-1:0]  out_ofs,
    output logic              out_ofs_wrap,
    output logic              out_fault
);

    // Three OFS_W operands can carry at most two bits past OFS_W.
    localparam int SUM_W    = OFS_W + 2;
    localparam int SEG_SH_W = SEG_W + SEG_SHIFT;
    localparam int CALC_W0  = (SEG_SH_W > OFS_W) ? SEG_SH_W : OFS_W;
    localparam int CALC_W   = ((CALC_W0 > ADDR_W) ? CALC_W0 : ADDR_W) + 1;

    typedef enum logic [2:0] {
        OP_IP           = 3'd0,
        OP_REL          = 3'd1,
        OP_REG1         = 3'd2,
        OP_REG1_REL     = 3'd3,
        OP_REG1_REG2    = 3'd4,
        OP_REG1_REG2_REL = 3'd5
    } op_e;

    // Stage 1 state
    logic             s1_valid_q;
    logic [OFS_W-1:0] s1_ofs_q;
    logic             s1_wrap_q;
    logic [SEG_W-1:0] s1_seg_q;
    logic [OFS_W-1:0] s1_limit_q;

    // Stage 2 state (drives the outputs directly)
    logic              s2_valid_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [OFS_W-1:0]  s2_ofs_q;
    logic              s2_wrap_q;
    logic              s2_fault_q;

    // Next-state values
    logic [OFS_W-1:0]  s1_ofs_d;
    logic              s1_wrap_d;
    logic [ADDR_W-1:0] s2_addr_d;
    logic              s2_fault_d;

    logic [SUM_W-1:0]  sel_sum;
    logic [CALC_W-1:0] addr_full;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    // Stage 2 may load when it is empty or its result leaves this cycle;
    // in_ready depends only on state and out_ready, never on in_valid.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;

    // Select the addressing-mode sum at full precision and derive offset/wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        sel_sum = SUM_W'(in_reg1);
        case (in_op)
            OP_IP:            sel_sum = SUM_W'(in_ip);
            OP_REL:           sel_sum = SUM_W'(in_rel);
            OP_REG1:          sel_sum = SUM_W'(in_reg1);
            OP_REG1_REL:      sel_sum = SUM_W'(in_reg1) + SUM_W'(in_rel);
            OP_REG1_REG2:     sel_sum = SUM_W'(in_reg1) + SUM_W'(in_reg2);
            OP_REG1_REG2_REL: sel_sum = SUM_W'(in_reg1) + SUM_W'(in_reg2) + SUM_W'(in_rel);
            default:          sel_sum = SUM_W'(in_reg1);
        endcase
        s1_ofs_d  = sel_sum[OFS_W-1:0];
        s1_wrap_d = |sel_sum[SUM_W-1:OFS_W];
    end

    // Form the physical address (wraps modulo 2^ADDR_W) and the limit check.
    always_comb begin
        addr_full  = (CALC_W'(s1_seg_q) << SEG_SHIFT) + CALC_W'(s1_ofs_q);
        s2_addr_d  = addr_full[ADDR_W-1:0];
        s2_fault_d = (s1_ofs_q > s1_limit_q);
    end

    // Stage 1 register: loads on every accepted request, empties on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // flop samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ofs_q   <= '0;
            s1_wrap_q  <= 1'b0;
            s1_seg_q   <= '0;
            s1_limit_q <= '0;
        end else begin
            s1_valid_q <= accept || (s1_valid_q && !s2_adv);
            if (accept) begin
                s1_ofs_q   <= s1_ofs_d;
                s1_wrap_q  <= s1_wrap_d;
                s1_seg_q   <= in_seg;
                s1_limit_q <= in_limit;
            end
        end
    end

    // Stage 2 register: advances when free or consumed, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_ofs_q   <= '0;
            s2_wrap_q  <= 1'b0;
            s2_fault_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_adv) begin
                s2_addr_q  <= s2_addr_d;
                s2_ofs_q   <= s1_ofs_q;
                s2_wrap_q  <= s1_wrap_q;
                s2_fault_q <= s2_fault_d;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_addr     = s2_addr_q;
    assign out_ofs      = s2_ofs_q;
    assign out_ofs_wrap = s2_wrap_q;
    assign out_fault    = s2_fault_q;

endmodule

// File: tb/tb_agu_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for agu_pipe: directed steps plus a random stream, with
// a scoreboard of model results compared whenever the DUT presents a result.
module tb_agu_pipe;

    localparam int OFS_W     = 16;
    localparam int SEG_W     = 16;
    localparam int SEG_SHIFT = 4;
    localparam int ADDR_W    = 20;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [OFS_W-1:0]  ofs;
        logic              wrap;
        logic              fault;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [OFS_W-1:0]  in_rel;
    logic [SEG_W-1:0]  in_seg;
    logic [OFS_W-1:0]  in_ip;
    logic [OFS_W-1:0]  in_reg1;
    logic [OFS_W-1:0]  in_reg2;
    logic [OFS_W-1:0]  in_limit;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [OFS_W-1:0]  out_ofs;
    logic              out_ofs_wrap;
    logic              out_fault;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic pend_q = 1'b0;

    agu_pipe #(
        .OFS_W(OFS_W), .SEG_W(SEG_W), .SEG_SHIFT(SEG_SHIFT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rel(in_rel), .in_seg(in_seg), .in_ip(in_ip),
        .in_reg1(in_reg1), .in_reg2(in_reg2), .in_limit(in_limit),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_ofs(out_ofs), .out_ofs_wrap(out_ofs_wrap), .out_fault(out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] rel,
                                   input logic [15:0] seg, input logic [15:0] ip,
                                   input logic [15:0] r1, input logic [15:0] r2,
                                   input logic [15:0] lim);
        exp_t m;
        int unsigned sum;
        int unsigned a;
        case (op)
            3'd0:    sum = 32'(ip);
            3'd1:    sum = 32'(rel);
            3'd3:    sum = 32'(r1) + 32'(rel);
            3'd4:    sum = 32'(r1) + 32'(r2);
            3'd5:    sum = 32'(r1) + 32'(r2) + 32'(rel);
            default: sum = 32'(r1);
        endcase
        m.wrap  = (sum > 32'h0000_FFFF);
        m.ofs   = sum[15:0];
        a       = 32'(seg) * 32'd16 + 32'(m.ofs);
        m.addr  = a[19:0];
        m.fault = (m.ofs > lim);
        return m;
    endfunction

    // Scoreboard: compare the head entry while a result is shown, pop on
    // consume, push on accept. Reset discards everything in flight.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            pend_q = 1'b0;
        end else begin
            if (pend_q) check("valid_held_until_consumed", out_valid, 1);
            if (sb.size() == 0) begin
                check("no_spurious_out", out_valid, 0);
            end else if (out_valid === 1'b1) begin
                check("sb_addr",  out_addr,     sb[0].addr);
                check("sb_ofs",   out_ofs,      sb[0].ofs);
                check("sb_wrap",  out_ofs_wrap, sb[0].wrap);
                check("sb_fault", out_fault,    sb[0].fault);
                if (out_ready) void'(sb.pop_front());
            end
            pend_q = (out_valid === 1'b1) && !out_ready;
            if (in_valid && in_ready === 1'b1)
                sb.push_back(model(in_op, in_rel, in_seg, in_ip, in_reg1, in_reg2, in_limit));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [15:0] rel,
                        input logic [15:0] seg, input logic [15:0] ip,
                        input logic [15:0] r1, input logic [15:0] r2,
                        input logic [15:0] lim);
        int n = 0;
        in_op = op; in_rel = rel; in_seg = seg; in_ip = ip;
        in_reg1 = r1; in_reg2 = r2; in_limit = lim;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                check("send_timeout", in_ready, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        step();
        in_valid = 1'b0;
    endtask

    // Called right after send(): result must appear exactly two edges later.
    task automatic check_result(input string tag, input logic [19:0] a, input logic [15:0] o,
                                input logic w, input logic f);
        @(negedge clk);
        check({tag, "_latency_early"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_addr"},  out_addr, a);
        check({tag, "_ofs"},   out_ofs, o);
        check({tag, "_wrap"},  out_ofs_wrap, w);
        check({tag, "_fault"}, out_fault, f);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        // A request held during reset must be dropped.
        in_valid = 1'b1; in_op = 3'd0; in_rel = '0; in_seg = 16'h1234; in_ip = 16'h0022;
        in_reg1 = '0; in_reg2 = '0; in_limit = 16'hFFFF;
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr",  out_addr, 0);
        check("rst_out_ofs",   out_ofs, 0);
        check("rst_out_wrap",  out_ofs_wrap, 0);
        check("rst_out_fault", out_fault, 0);
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk) check("no_result_from_reset_req", out_valid, 0);
        step();

        // Directed mode/boundary vectors
        send(3'd0, 16'h0000, 16'h1234, 16'h0022, 16'h0000, 16'h0000, 16'hFFFF);
        check_result("ip_mode", 20'h12362, 16'h0022, 1'b0, 1'b0);
        step();
        send(3'd5, 16'h0001, 16'h0100, 16'h0000, 16'hFFFF, 16'h0002, 16'hFFFF);
        check_result("ofs_wrap", 20'h01002, 16'h0002, 1'b1, 1'b0);
        step();
        send(3'd1, 16'h0010, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        check_result("addr_wrap", 20'h00000, 16'h0010, 1'b0, 1'b0);
        step();
        send(3'd3, 16'h0001, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100);
        check_result("limit_fault", 20'h00101, 16'h0101, 1'b0, 1'b1);
        step();
        send(3'd3, 16'h0001, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0101);
        check_result("limit_ok", 20'h00101, 16'h0101, 1'b0, 1'b0);
        step();

        // Backpressure: A and B fill the pipe, C waits, A holds on the output.
        out_ready = 1'b0;
        send(3'd2, 16'h0000, 16'h0010, 16'h0000, 16'h0200, 16'h0000, 16'hFFFF);
        send(3'd4, 16'h0000, 16'h0020, 16'h0000, 16'h0010, 16'h0020, 16'hFFFF);
        in_op = 3'd6; in_rel = '0; in_seg = 16'h0000; in_ip = '0;
        in_reg1 = 16'h0777; in_reg2 = '0; in_limit = 16'hFFFF;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_hold_addr_a", out_addr, 20'h00300);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_a_valid", out_valid, 1);
        check("release_a_addr", out_addr, 20'h00300);
        step();
        in_valid = 1'b0;
        check("release_b_addr", out_addr, 20'h00230);
        @(negedge clk) check("release_b_valid", out_valid, 1);
        @(negedge clk);
        check("release_c_valid", out_valid, 1);
        check("release_c_addr", out_addr, 20'h00777);
        @(negedge clk) check("release_drained", out_valid, 0);
        step();

        // Reset with two requests in flight flushes them.
        out_ready = 1'b0;
        send(3'd0, 16'h0000, 16'h0001, 16'h0005, 16'h0000, 16'h0000, 16'hFFFF);
        send(3'd0, 16'h0000, 16'h0002, 16'h0006, 16'h0000, 16'h0000, 16'hFFFF);
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk) check("flush_no_stale", out_valid, 0);
        step();
        send(3'd4, 16'h0000, 16'h0002, 16'h0000, 16'h1000, 16'h0234, 16'hFFFF);
        check_result("post_flush", 20'h01254, 16'h1234, 1'b0, 1'b0);
        step();

        // Random traffic with random backpressure; scoreboard checks order.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_rel    = 16'($urandom);
            in_seg    = 16'($urandom);
            in_ip     = 16'($urandom);
            in_reg1   = 16'($urandom);
            in_reg2   = 16'($urandom);
            in_limit  = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        check("drain_scoreboard_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
